mem_wb_reg: RTL and testbench

MEM_WB_REG -- requirements
Module: mem_wb_reg

---
 rtl/mem_wb_reg.sv | 102 ++++++++++
 tb/tb_mem_wb_reg.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with big-endian load extraction for the writeback mux.
// Optional retired-instruction counter on wb_retired, enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_pc_plus8,
    input  logic [31:0] mem_imm,
    input  logic [1:0]  mem_wb_sel,
    input  logic        mem_reg_wen,
    input  logic [4:0]  mem_rd,
    input  logic [2:0]  mem_ld_type,
    output logic [31:0] wb_din_0,
    output logic [31:0] wb_din_1,
    output logic [31:0] wb_din_2,
    output logic [31:0] wb_din_3,
    output logic [1:0]  wb_sel,
    output logic        wb_reg_wen,
    output logic [4:0]  wb_rd,
    output logic        wb_valid
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] wb_retired
`endif
);

    localparam logic [2:0] LD_WORD = 3'b000;
    localparam logic [2:0] LD_BS   = 3'b001;
    localparam logic [2:0] LD_BU   = 3'b010;
    localparam logic [2:0] LD_HS   = 3'b011;
    localparam logic [2:0] LD_HU   = 3'b100;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Big-endian lanes: the lowest address holds the most significant byte.
    always_comb begin
        load_byte = mem_rdata[31:24];
        case (mem_alu_res[1:0])
            2'd0:    load_byte = mem_rdata[31:24];
            2'd1:    load_byte = mem_rdata[23:16];
            2'd2:    load_byte = mem_rdata[15:8];
            default: load_byte = mem_rdata[7:0];
        endcase
        load_half = mem_alu_res[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    end

    always_comb begin
        load_data = mem_rdata;
        case (mem_ld_type)
            LD_WORD: load_data = mem_rdata;
            LD_BS:   load_data = {{24{load_byte[7]}}, load_byte};
            LD_BU:   load_data = {24'h000000, load_byte};
            LD_HS:   load_data = {{16{load_half[15]}}, load_half};
            LD_HU:   load_data = {16'h0000, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb_din_0   <= 32'h0;
            wb_din_1   <= 32'h0;
            wb_din_2   <= 32'h0;
            wb_din_3   <= 32'h0;
            wb_sel     <= 2'b00;
            wb_reg_wen <= 1'b0;
            wb_rd      <= 5'd0;
            wb_valid   <= 1'b0;
        end else if (!stall) begin
            wb_din_0   <= mem_alu_res;
            wb_din_1   <= load_data;
            wb_din_2   <= mem_pc_plus8;
            wb_din_3   <= mem_imm;
            wb_sel     <= mem_wb_sel;
            // x0 is hardwired, so a write to it is squashed here rather than in the regfile.
            wb_reg_wen <= mem_reg_wen & mem_valid & (mem_rd != 5'd0);
            wb_rd      <= mem_rd;
            wb_valid   <= mem_valid;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= 32'h0;
        end else if (!flush && !stall && mem_valid) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    assign wb_retired = retired_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: directed scenarios plus randomized traffic
// against a behavioural model; the counter checks build only with WB_RETIRE_CNT_EN.
module tb_mem_wb_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_alu_res = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem_pc_plus8 = 32'h0;
    logic [31:0] mem_imm = 32'h0;
    logic [1:0]  mem_wb_sel = 2'b00;
    logic        mem_reg_wen = 1'b0;
    logic [4:0]  mem_rd = 5'd0;
    logic [2:0]  mem_ld_type = 3'b000;
    logic [31:0] wb_din_0, wb_din_1, wb_din_2, wb_din_3;
    logic [1:0]  wb_sel;
    logic        wb_reg_wen;
    logic [4:0]  wb_rd;
    logic        wb_valid;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] wb_retired;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the WB-side state.
    logic [31:0] e_din [4];
    logic [1:0]  e_sel;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic        e_valid;
    logic [31:0] e_ret;

    mem_wb_reg dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_alu_res  (mem_alu_res),
        .mem_rdata    (mem_rdata),
        .mem_pc_plus8 (mem_pc_plus8),
        .mem_imm      (mem_imm),
        .mem_wb_sel   (mem_wb_sel),
        .mem_reg_wen  (mem_reg_wen),
        .mem_rd       (mem_rd),
        .mem_ld_type  (mem_ld_type),
        .wb_din_0     (wb_din_0),
        .wb_din_1     (wb_din_1),
        .wb_din_2     (wb_din_2),
        .wb_din_3     (wb_din_3),
        .wb_sel       (wb_sel),
        .wb_reg_wen   (wb_reg_wen),
        .wb_rd        (wb_rd),
        .wb_valid     (wb_valid)
`ifdef WB_RETIRE_CNT_EN
        ,
        .wb_retired   (wb_retired)
`endif
    );

    always #5 clk = ~clk;

    // Load value computed arithmetically: shift the addressed lane down, mask, then sign-fix.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] ld_type);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * (3 - (addr % 4)))) & 32'hFF;
        h = (rdata >> ((addr % 4) >= 2 ? 0 : 16)) & 32'hFFFF;
        case (ld_type)
            3'd1:    return (b >= 128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [136:0] act_vec();
        return {wb_din_0, wb_din_1, wb_din_2, wb_din_3, wb_sel, wb_reg_wen, wb_rd, wb_valid};
    endfunction

    function automatic logic [136:0] exp_vec();
        return {e_din[0], e_din[1], e_din[2], e_din[3], e_sel, e_wen, e_rd, e_valid};
    endfunction

    task automatic randomize_inputs();
        mem_valid    = 1'($urandom);
        mem_alu_res  = $urandom;
        mem_rdata    = $urandom;
        mem_pc_plus8 = $urandom;
        mem_imm      = $urandom;
        mem_wb_sel   = 2'($urandom);
        mem_reg_wen  = 1'($urandom);
        mem_rd       = 5'($urandom);
        mem_ld_type  = 3'($urandom);
    endtask

    // Advance the model by one edge from the current inputs, then clock the DUT and settle.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 4; i++) e_din[i] = 32'h0;
            e_sel = 0; e_wen = 0; e_rd = 0; e_valid = 0; e_ret = 0;
        end else if (flush) begin
            for (int i = 0; i < 4; i++) e_din[i] = 32'h0;
            e_sel = 0; e_wen = 0; e_rd = 0; e_valid = 0;
        end else if (!stall) begin
            e_din[0] = mem_alu_res;
            e_din[1] = ref_load(mem_rdata, mem_alu_res, mem_ld_type);
            e_din[2] = mem_pc_plus8;
            e_din[3] = mem_imm;
            e_sel    = mem_wb_sel;
            e_wen    = mem_reg_wen && mem_valid && (mem_rd != 0);
            e_rd     = mem_rd;
            e_valid  = mem_valid;
            if (mem_valid) e_ret = e_ret + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        randomize_inputs();
        rst = 1'b1; stall = 1'($urandom); flush = 1'($urandom);
        model_edge();
        vectors++;
        if (act_vec() !== 137'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h want 0", act_vec());
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b1; mem_alu_res = 32'h00001234; mem_wb_sel = 2'b00;
        mem_rd = 5'd8; mem_reg_wen = 1'b1;
        model_edge();
        vectors++;
        if ({wb_din_0, wb_reg_wen, wb_rd} !== {32'h00001234, 1'b1, 5'd8}) begin
            miscompares++;
            $display("[TB] FAIL first_capture: got din0=%h wen=%b rd=%0d want 00001234/1/8",
                     wb_din_0, wb_reg_wen, wb_rd);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  types [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [31:0] addrs [5] = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h103};
        logic [31:0] wants [5] = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'h000080FF, 32'h80FF7F01};
        mem_rdata = 32'h80FF7F01; mem_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ld_type = types[i]; mem_alu_res = addrs[i];
            model_edge();
            vectors++;
            if (wb_din_1 !== wants[i]) begin
                miscompares++;
                $display("[TB] FAIL load_directed_%0d: got %h want %h", i, wb_din_1, wants[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            randomize_inputs();
            model_edge();
            vectors++;
            if (wb_din_1 !== e_din[1]) begin
                miscompares++;
                $display("[TB] FAIL load_random: type=%0d got %h want %h", mem_ld_type, wb_din_1, e_din[1]);
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [136:0] held;
        randomize_inputs();
        mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_rd = 5'd5;
        model_edge();
        held = exp_vec();
        vectors++;
        if (wb_rd !== 5'd5 || wb_reg_wen !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_capture: got rd=%0d wen=%b want 5/1", wb_rd, wb_reg_wen);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            model_edge();
            vectors++;
            if (act_vec() !== held) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_%0d: got %h want %h", i, act_vec(), held);
            end
        end
        flush = 1'b1;
        randomize_inputs();
        model_edge();
        vectors++;
        if (act_vec() !== 137'd0) begin
            miscompares++;
            $display("[TB] FAIL stall_flush: got %h want 0", act_vec());
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reg_zero();
        randomize_inputs();
        mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_rd = 5'd0;
        model_edge();
        vectors++;
        if ({wb_reg_wen, wb_valid} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rd_zero: got wen=%b valid=%b want 0/1", wb_reg_wen, wb_valid);
        end
        mem_valid = 1'b0; mem_rd = 5'd9;
        model_edge();
        vectors++;
        if ({wb_reg_wen, wb_valid, wb_rd} !== {1'b0, 1'b0, 5'd9}) begin
            miscompares++;
            $display("[TB] FAIL invalid_wen: got wen=%b valid=%b rd=%0d want 0/0/9",
                     wb_reg_wen, wb_valid, wb_rd);
        end
    endtask

    task automatic test_reset_priority();
        randomize_inputs();
        mem_valid = 1'b1;
        model_edge();
        stall = 1'b1; flush = 1'b1; rst = 1'b1;
        randomize_inputs();
        model_edge();
        vectors++;
        if (act_vec() !== 137'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_over_stall: got %h want 0", act_vec());
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        randomize_inputs();
        model_edge();
        vectors++;
        if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL resume_after_reset: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            rst   = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            model_edge();
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: got %h want %h", i, act_vec(), exp_vec());
            end
`ifdef WB_RETIRE_CNT_EN
            vectors++;
            if (wb_retired !== e_ret) begin
                miscompares++;
                $display("[TB] FAIL random_retired_%0d: got %h want %h", i, wb_retired, e_ret);
            end
`endif
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire_counter();
        rst = 1'b1;
        model_edge();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            randomize_inputs();
            mem_valid = 1'b1;
            stall = (i == 2);
            flush = (i == 4);
            model_edge();
            vectors++;
            if (wb_retired !== e_ret) begin
                miscompares++;
                $display("[TB] FAIL retired_count_%0d: got %h want %h", i, wb_retired, e_ret);
            end
        end
        stall = 1'b0; flush = 1'b0;
        force dut.retired_cnt = 32'hFFFFFFFE;
        #1;
        release dut.retired_cnt;
        e_ret = 32'hFFFFFFFE;
        mem_valid = 1'b1;
        model_edge();
        vectors++;
        if (wb_retired !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("[TB] FAIL retired_max: got %h want ffffffff", wb_retired);
        end
        model_edge();
        vectors++;
        if (wb_retired !== 32'h00000000) begin
            miscompares++;
            $display("[TB] FAIL retired_wrap: got %h want 00000000", wb_retired);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) e_din[i] = 32'h0;
        e_sel = 0; e_wen = 0; e_rd = 0; e_valid = 0; e_ret = 0;
        @(negedge clk);
        test_reset();
        test_loads();
        test_stall_flush();
        test_reg_zero();
        test_reset_priority();
        test_back_to_back();
`ifdef WB_RETIRE_CNT_EN
        test_retire_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
